// File: rtl/tx_re_engine.sv
// Ultrasonic transmit/receive sequencer: drives a complementary transducer burst,
// then measures the echo time-of-flight after a blanking interval or times out.
module tx_re_engine #(
    parameter int HALF_PERIOD = 1250,
    parameter int NUM_PULSES  = 8,
    parameter int BLANK_CYC   = 50000,
    parameter int RE_TIMEOUT  = 2500000
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic        enTx,
    output logic        overTx,
    input  logic        enRe,
    output logic        overRe,
    input  logic        echo_in,
    output logic        tx_p,
    output logic        tx_n,
    output logic [23:0] tof,
    output logic        tof_valid,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE,
        TX_BURST,
        WAIT_RE,
        RE_BLANK,
        RE_LISTEN
    } state_t;

    localparam logic [31:0] HALF_LAST  = 32'(HALF_PERIOD - 1);
    localparam logic [31:0] HALF_COUNT = 32'(2 * NUM_PULSES - 1);
    localparam logic [23:0] BLANK_LAST = 24'(BLANK_CYC - 1);
    localparam logic [23:0] TO_LAST    = 24'(RE_TIMEOUT - 1);
    localparam logic [23:0] CNT_MAX    = 24'hFF_FFFF;

    state_t      state_reg, state_next;
    logic [31:0] half_cnt_reg, half_cnt_next;
    logic [31:0] half_idx_reg, half_idx_next;
    logic        phase_reg, phase_next;
    logic [23:0] re_cnt_reg, re_cnt_next;
    logic        over_tx_reg, over_tx_next;
    logic        over_re_reg, over_re_next;
    logic [23:0] tof_reg, tof_next;
    logic        tof_valid_reg, tof_valid_next;
    logic        timeout_reg, timeout_next;

    // sync_reg[1] is the synchronized echo; sync_reg[2] its previous value
    logic [2:0]  sync_reg;
    logic        rise_reg;

    always_ff @(posedge clk_100) begin
        if (rst) begin
            sync_reg <= '0;
            rise_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[1:0], echo_in};
            rise_reg <= sync_reg[1] & ~sync_reg[2];
        end
    end

    always_ff @(posedge clk_100) begin
        if (rst) begin
            state_reg     <= IDLE;
            half_cnt_reg  <= '0;
            half_idx_reg  <= '0;
            phase_reg     <= 1'b0;
            re_cnt_reg    <= '0;
            over_tx_reg   <= 1'b0;
            over_re_reg   <= 1'b0;
            tof_reg       <= '0;
            tof_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            half_cnt_reg  <= half_cnt_next;
            half_idx_reg  <= half_idx_next;
            phase_reg     <= phase_next;
            re_cnt_reg    <= re_cnt_next;
            over_tx_reg   <= over_tx_next;
            over_re_reg   <= over_re_next;
            tof_reg       <= tof_next;
            tof_valid_reg <= tof_valid_next;
            timeout_reg   <= timeout_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        half_cnt_next  = half_cnt_reg;
        half_idx_next  = half_idx_reg;
        phase_next     = phase_reg;
        re_cnt_next    = re_cnt_reg;
        over_tx_next   = 1'b0;
        over_re_next   = 1'b0;
        tof_next       = tof_reg;
        tof_valid_next = tof_valid_reg;
        timeout_next   = timeout_reg;

        case (state_reg)
            IDLE: begin
                if (enTx) begin
                    state_next     = TX_BURST;
                    half_cnt_next  = '0;
                    half_idx_next  = '0;
                    phase_next     = 1'b1;
                    tof_valid_next = 1'b0;
                    timeout_next   = 1'b0;
                end
            end
            TX_BURST: begin
                // Dropping enTx aborts even on the final burst cycle
                if (!enTx) begin
                    state_next = IDLE;
                end else if (half_cnt_reg == HALF_LAST) begin
                    half_cnt_next = '0;
                    phase_next    = ~phase_reg;
                    if (half_idx_reg == HALF_COUNT) begin
                        state_next   = WAIT_RE;
                        over_tx_next = 1'b1;
                    end else begin
                        half_idx_next = half_idx_reg + 32'd1;
                    end
                end else begin
                    half_cnt_next = half_cnt_reg + 32'd1;
                end
            end
            WAIT_RE: begin
                if (enRe) begin
                    state_next  = RE_BLANK;
                    re_cnt_next = '0;
                end else if (!enTx) begin
                    state_next = IDLE;
                end
            end
            RE_BLANK: begin
                if (!enRe) begin
                    state_next = IDLE;
                end else begin
                    if (re_cnt_reg == BLANK_LAST) begin
                        state_next = RE_LISTEN;
                    end
                    re_cnt_next = (re_cnt_reg == CNT_MAX) ? re_cnt_reg : re_cnt_reg + 24'd1;
                end
            end
            RE_LISTEN: begin
                if (!enRe) begin
                    state_next = IDLE;
                end else if (rise_reg) begin
                    state_next     = IDLE;
                    tof_next       = re_cnt_reg;
                    tof_valid_next = 1'b1;
                    timeout_next   = 1'b0;
                    over_re_next   = 1'b1;
                end else if (re_cnt_reg == TO_LAST) begin
                    state_next     = IDLE;
                    tof_next       = '0;
                    tof_valid_next = 1'b0;
                    timeout_next   = 1'b1;
                    over_re_next   = 1'b1;
                end else begin
                    re_cnt_next = (re_cnt_reg == CNT_MAX) ? re_cnt_reg : re_cnt_reg + 24'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_p      = (state_reg == TX_BURST) &&  phase_reg;
    assign tx_n      = (state_reg == TX_BURST) && !phase_reg;
    assign overTx    = over_tx_reg;
    assign overRe    = over_re_reg;
    assign tof       = tof_reg;
    assign tof_valid = tof_valid_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_tx_re_engine.sv
// Scenario bench for tx_re_engine with small parameters; receive-window results
// are predicted into a scoreboard queue and compared when overRe fires.
module tb_tx_re_engine;

    localparam int H     = 4;
    localparam int N     = 2;
    localparam int BLANK = 10;
    localparam int TO    = 100;

    logic        clk;
    logic        rst;
    logic        enTx;
    logic        enRe;
    logic        echo_in;
    logic        overTx;
    logic        overRe;
    logic        tx_p;
    logic        tx_n;
    logic [23:0] tof;
    logic        tof_valid;
    logic        timeout;

    typedef struct {
        logic [23:0] tof;
        logic        valid;
        logic        to;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [23:0] last_tof = '0;

    tx_re_engine #(
        .HALF_PERIOD(H),
        .NUM_PULSES (N),
        .BLANK_CYC  (BLANK),
        .RE_TIMEOUT (TO)
    ) dut (
        .clk_100  (clk),
        .rst      (rst),
        .enTx     (enTx),
        .overTx   (overTx),
        .enRe     (enRe),
        .overRe   (overRe),
        .echo_in  (echo_in),
        .tx_p     (tx_p),
        .tx_n     (tx_n),
        .tof      (tof),
        .tof_valid(tof_valid),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; enTx = 1'b0; enRe = 1'b0; echo_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_p, tx_n, overTx, overRe, tof, tof_valid, timeout} !== 30'd0) begin
            errors++;
            $display("FAIL reset: outputs=%h required 0",
                     {tx_p, tx_n, overTx, overRe, tof, tof_valid, timeout});
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: outputs cleared");
    endtask

    // Starts from IDLE with enTx low; returns at the negedge of the overTx cycle.
    task automatic test_burst();
        logic exp_p;
        enTx = 1'b1; enRe = 1'b0;
        for (int i = 1; i <= 2 * N * H; i++) begin
            @(negedge clk);
            exp_p = (((i - 1) / H) % 2) == 0;
            checks++;
            if (tx_p !== exp_p || tx_n !== !exp_p) begin
                errors++;
                $display("FAIL burst_drive cycle %0d: tx_p=%b tx_n=%b required %b %b",
                         i, tx_p, tx_n, exp_p, !exp_p);
            end
            checks++;
            if (overTx !== 1'b0) begin
                errors++;
                $display("FAIL burst_early_overTx cycle %0d: overTx=%b required 0", i, overTx);
            end
            if (i == 1) begin
                checks++;
                if (tof_valid !== 1'b0 || timeout !== 1'b0 || tof !== last_tof) begin
                    errors++;
                    $display("FAIL burst_start_status: tof=%0d valid=%b timeout=%b required %0d 0 0",
                             tof, tof_valid, timeout, last_tof);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (overTx !== 1'b1 || tx_p !== 1'b0 || tx_n !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: overTx=%b tx_p=%b tx_n=%b required 1 0 0", overTx, tx_p, tx_n);
        end
        $display("burst: %0d cycles driven, overTx checked", 2 * N * H);
    endtask

    // Entered at the overTx negedge; echo_at/echo_off are receive-counter cycles (-1 = never).
    task automatic test_receive(input int echo_at, input int echo_off);
        exp_t e;
        bit   seen;
        enRe = 1'b1; enTx = 1'b0;
        if (echo_at >= 0 && echo_at + 3 >= BLANK && echo_at + 3 <= TO - 1) begin
            e.tof = 24'(echo_at + 3); e.valid = 1'b1; e.to = 1'b0; e.at = echo_at + 4;
        end else begin
            e.tof = 24'd0; e.valid = 1'b0; e.to = 1'b1; e.at = TO;
        end
        sb.push_back(e);
        seen = 1'b0;
        for (int b = 0; b <= TO + 20 && !seen; b++) begin
            @(negedge clk);
            checks++;
            if (overTx !== 1'b0) begin
                errors++;
                $display("FAIL window_overTx cycle %0d: overTx=%b required 0", b, overTx);
            end
            if (overRe === 1'b1) begin
                seen = 1'b1;
                e = sb.pop_front();
                checks++;
                if (b != e.at) begin
                    errors++;
                    $display("FAIL window_overRe_cycle: got cycle %0d required %0d", b, e.at);
                end
                checks++;
                if (tof !== e.tof || tof_valid !== e.valid || timeout !== e.to) begin
                    errors++;
                    $display("FAIL window_result: tof=%0d valid=%b timeout=%b required %0d %b %b",
                             tof, tof_valid, timeout, e.tof, e.valid, e.to);
                end
                last_tof = e.tof;
                $display("window: echo_at=%0d tof=%0d valid=%b timeout=%b at cycle %0d",
                         echo_at, tof, tof_valid, timeout, b);
            end
            if (b == echo_at) echo_in = 1'b1;
            if (b == echo_off) echo_in = 1'b0;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL window_no_overRe: overRe=0 after %0d cycles required 1", TO + 20);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        enRe = 1'b0; echo_in = 1'b0;
        @(negedge clk);
        checks++;
        if (overRe !== 1'b0 || tof !== last_tof) begin
            errors++;
            $display("FAIL window_hold: overRe=%b tof=%0d required 0 %0d", overRe, tof, last_tof);
        end
    endtask

    task automatic test_abort_tx();
        int bad;
        enTx = 1'b1; enRe = 1'b0;
        for (int i = 1; i <= 6; i++) @(negedge clk);
        enTx = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_p !== 1'b0 || tx_n !== 1'b0) begin
            errors++;
            $display("FAIL abort_tx_drive: tx_p=%b tx_n=%b required 0 0", tx_p, tx_n);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (overTx !== 1'b0 || tx_p !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_tx_idle: %0d active cycles required 0", bad);
        end
        $display("abort_tx: burst dropped at cycle 6, restarting");
        test_burst();
        enTx = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wait_idle();
        int bad;
        test_burst();
        enTx = 1'b0; enRe = 1'b0;
        @(negedge clk);
        enRe = 1'b1;
        bad = 0;
        repeat (TO + 15) begin
            @(negedge clk);
            if (overRe !== 1'b0 || overTx !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_ignores_enRe: %0d pulses required 0", bad);
        end
        enRe = 1'b0;
        @(negedge clk);
        $display("wait_idle: enRe ignored in IDLE");
    endtask

    task automatic test_re_abort();
        int bad;
        test_burst();
        enRe = 1'b1; enTx = 1'b0;
        repeat (21) @(negedge clk);
        enRe = 1'b0;
        bad = 0;
        repeat (TO + 10) begin
            @(negedge clk);
            if (overRe !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL re_abort_overRe: %0d pulses required 0", bad);
        end
        checks++;
        if (tof !== last_tof || tof_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL re_abort_status: tof=%0d valid=%b timeout=%b required %0d 0 0",
                     tof, tof_valid, timeout, last_tof);
        end
        $display("re_abort: window abandoned, status held");
    endtask

    task automatic test_rst_listen();
        int bad;
        test_burst();
        enRe = 1'b1; enTx = 1'b0;
        repeat (51) @(negedge clk);
        checks++;
        if (tof !== last_tof || last_tof == 24'd0) begin
            errors++;
            $display("FAIL rst_pre_tof: tof=%0d required nonzero %0d", tof, last_tof);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_p, tx_n, overTx, overRe, tof, tof_valid, timeout} !== 30'd0) begin
            errors++;
            $display("FAIL rst_listen_outputs: outputs=%h required 0",
                     {tx_p, tx_n, overTx, overRe, tof, tof_valid, timeout});
        end
        rst = 1'b0;
        last_tof = '0;
        bad = 0;
        repeat (TO + 20) begin
            @(negedge clk);
            if (overRe !== 1'b0 || overTx !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_listen_no_pulse: %0d pulses required 0", bad);
        end
        enRe = 1'b0;
        @(negedge clk);
        $display("rst_listen: reset during receive window");
    endtask

    initial begin
        test_reset();
        test_burst(); test_receive(30, -1);
        test_burst(); test_receive(-1, -1);
        test_burst(); test_receive(2, 4);
        test_burst(); test_receive(7, -1);
        test_burst(); test_receive(97, -1);
        test_burst(); test_receive(96, -1);
        test_abort_tx();
        test_wait_idle();
        test_re_abort();
        test_rst_listen();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_re_engine.md
TX_RE_ENGINE -- requirements
Module: tx_re_engine

Interface
REQ-001 Parameter HALF_PERIOD, 1250: clk_100 cycles per burst half-period (40 kHz at 100 MHz); legal range >= 2.
REQ-002 Parameter NUM_PULSES, 8: full burst periods per transmit; legal range >= 1.
REQ-003 Parameter BLANK_CYC, 50000: receive blanking cycles after burst; legal range >= 1.
REQ-004 Parameter RE_TIMEOUT, 2500000: receive window length in cycles counted from first blank cycle; legal range > BLANK_CYC, < 2^24.
REQ-005 clk_100  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 enTx  in  1  transmit enable level from controller.
REQ-008 overTx  out  1  one-cycle pulse: burst complete.
REQ-009 enRe  in  1  receive enable level from controller.
REQ-010 overRe  out  1  one-cycle pulse: receive window closed (echo or timeout).
REQ-011 echo_in  in  1  asynchronous comparator output from receive front-end.
REQ-012 tx_p / tx_n  out  1 each  complementary transducer drive.
REQ-013 tof  out  24  time-of-flight count of last measurement.
REQ-014 tof_valid  out  1  last measurement captured an echo.
REQ-015 timeout  out  1  last measurement ended without echo.

Function
REQ-016 States SHALL be IDLE, TX_BURST, WAIT_RE, RE_BLANK, RE_LISTEN.
REQ-017 IDLE: enTx sampled high -> TX_BURST next cycle; tof_valid and timeout cleared on that transition; enRe in IDLE ignored.
REQ-018 TX_BURST: tx_p = 1 in first TX_BURST cycle, toggles every HALF_PERIOD cycles; tx_n = ~tx_p; burst lasts exactly 2*NUM_PULSES*HALF_PERIOD cycles.
REQ-019 Outside TX_BURST tx_p and tx_n SHALL both be 0 (never both 1).
REQ-020 End of burst: overTx high for exactly the one cycle after the last burst cycle, state -> WAIT_RE.
REQ-021 enTx sampled low during TX_BURST: abort, tx_p/tx_n 0 next cycle, -> IDLE, no overTx.
REQ-022 WAIT_RE: enRe high -> RE_BLANK; enRe and enTx both low -> IDLE; enTx high only -> stay.
REQ-023 Receive counter (24 bit) SHALL be 0 in first RE_BLANK cycle, increment each cycle through RE_BLANK and RE_LISTEN, never wrap.
REQ-024 RE_BLANK lasts BLANK_CYC cycles, then RE_LISTEN; echo edges during RE_BLANK ignored.
REQ-025 echo_in SHALL pass a 2-flop synchronizer then rising-edge detect; only a synchronized 0->1 edge in RE_LISTEN counts.
REQ-026 Echo detected: tof <= counter value that cycle, tof_valid <= 1, timeout <= 0, overRe pulsed one cycle, -> IDLE.
REQ-027 Counter reaching RE_TIMEOUT-1 without echo: tof <= 0, tof_valid <= 0, timeout <= 1, overRe pulsed one cycle, -> IDLE.
REQ-028 Echo and timeout in same cycle: echo wins.
REQ-029 enRe sampled low in RE_BLANK/RE_LISTEN: abort -> IDLE, no overRe, tof/tof_valid/timeout unchanged.
REQ-030 tof, tof_valid, timeout SHALL hold until next IDLE->TX_BURST transition.
REQ-031 overTx and overRe SHALL never be high in the same cycle.

Reset
REQ-032 rst high at a clock edge: state IDLE, counters 0, synchronizer flops 0, all outputs 0 (tx_p, tx_n, overTx, overRe, tof, tof_valid, timeout).
REQ-033 rst mid-burst or mid-window SHALL take priority over all other events; no overTx/overRe generated.

Verification (HALF_PERIOD=4, NUM_PULSES=2, BLANK_CYC=10, RE_TIMEOUT=100)
REQ-034 enTx high held -> tx_p 1,1,1,1,0,0,0,0 x2 (16 cycles), tx_n inverse, overTx single pulse cycle 17.
REQ-035 After overTx, enRe high, echo_in rises 30 cycles after first blank cycle -> tof = 33 (sync+edge latency), tof_valid=1, overRe one pulse.
REQ-036 No echo -> overRe at counter 99, timeout=1, tof=0, tof_valid=0.
REQ-037 echo_in pulse during blanking only -> ignored, timeout path taken.
REQ-038 enTx dropped at burst cycle 6 -> tx_p=tx_n=0 next cycle, no overTx, IDLE; new enTx restarts full 16-cycle burst.
REQ-039 rst asserted during RE_LISTEN -> all outputs 0 next cycle, no overRe.
